// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter: one-word hold buffer feeding an MSB-first shifter.
// Optional SPI_TX_CS_EN adds an active-low chip select framing back-to-back word streams.
module spi_master_tx #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned WORD_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 spi_clk,
    output logic                 spi_mosi,
    output logic                 busy,
    output logic                 word_done
`ifdef SPI_TX_CS_EN
    ,
    output logic                 spi_cs_n
`endif
);

    localparam int unsigned BIT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int unsigned DIV_W = 8;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_e;

    state_e               state_q,   state_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0] shift_q,   shift_d;
    logic [WORD_BITS-1:0] hold_q,    hold_d;
    logic                 ready_q,   ready_d;
    logic                 sclk_q,    sclk_d;
    logic                 mosi_q,    mosi_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;
`ifdef SPI_TX_CS_EN
    logic                 cs_n_q,    cs_n_d;
`endif

    logic phase_end;
    logic load;
    logic accept;

    // Hold register is full exactly when in_ready is low.
    assign accept    = in_valid && ready_q;
    assign phase_end = (div_cnt_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q + DIV_W'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        hold_d    = hold_q;
        ready_d   = ready_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef SPI_TX_CS_EN
        cs_n_d    = cs_n_q;
`endif
        load      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                div_cnt_d = '0;
                if (!ready_q) begin
                    load = 1'b1;
                end
            end
            ST_LOW: begin
                if (phase_end) begin
                    state_d   = ST_HIGH;
                    sclk_d    = 1'b1;
                    div_cnt_d = '0;
                end
            end
            ST_HIGH: begin
                if (phase_end) begin
                    div_cnt_d = '0;
                    sclk_d    = 1'b0;
                    if (bit_cnt_q != '0) begin
                        shift_d   = {shift_q[WORD_BITS-2:0], 1'b0};
                        mosi_d    = shift_q[WORD_BITS-2];
                        bit_cnt_d = bit_cnt_q - BIT_W'(1);
                        state_d   = ST_LOW;
                    end else begin
                        done_d = 1'b1;
                        if (!ready_q) begin
                            // Buffered word streams on with no idle gap.
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            mosi_d  = 1'b0;
                            busy_d  = 1'b0;
`ifdef SPI_TX_CS_EN
                            cs_n_d  = 1'b1;
`endif
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Move the held word into the shifter and present its MSB.
        if (load) begin
            shift_d   = hold_q;
            bit_cnt_d = BIT_LAST;
            mosi_d    = hold_q[WORD_BITS-1];
            sclk_d    = 1'b0;
            busy_d    = 1'b1;
            div_cnt_d = '0;
            ready_d   = 1'b1;
            state_d   = ST_LOW;
`ifdef SPI_TX_CS_EN
            cs_n_d    = 1'b0;
`endif
        end

        if (accept) begin
            hold_d  = in_data;
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            hold_q    <= '0;
            ready_q   <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SPI_TX_CS_EN
            cs_n_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            ready_q   <= ready_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SPI_TX_CS_EN
            cs_n_q    <= cs_n_d;
`endif
        end
    end

    assign in_ready  = ready_q;
    assign spi_clk   = sclk_q;
    assign spi_mosi  = mosi_q;
    assign busy      = busy_q;
    assign word_done = done_q;
`ifdef SPI_TX_CS_EN
    assign spi_cs_n  = cs_n_q;
`endif

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- SPI master transmitter that feeds the matrix controller's SPI slave receiver, and the bench-side driver for it.
- Accepts 16-bit words on a valid/ready handshake, buffers one word, and serialises each MSB first on spi_clk/spi_mosi.
- Mode 0: spi_mosi changes while spi_clk is low; the receiver samples on the rising edge.
- No framing signal in the base build. The receiver stays word-aligned by being reset together with this block.

Parameters:
- CLK_DIV, 2, spi_clk half-period in clk cycles; legal range 1..255.
- WORD_BITS, 16, bits per word; fixed at 16 for the matrix controller and legal range 2..32.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- in_data  input  WORD_BITS  word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  hold register empty; a word is accepted on a clk edge where in_valid && in_ready.
- spi_clk  output  1  serial clock to the slave.
- spi_mosi  output  1  serial data, MSB first.
- busy  output  1  a word is currently shifting.
- word_done  output  1  one-cycle pulse after the last bit's high phase.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: spi_clk=0, spi_mosi=0, busy=0, word_done=0, in_ready=1. Hold register and shifter are emptied; state is IDLE.
- Hold register:
  - in_ready = !hold_full, taken directly from the register.
  - An accept sets hold_full on that edge.
  - hold_full clears on the edge its word moves into the shifter.
  - No accept is possible on a cycle where in_ready=0, even if the hold register empties on that same edge.
- Divider: counter div_cnt runs 0..CLK_DIV-1 within each phase and clears on every phase change.
- State IDLE:
  - spi_clk=0, spi_mosi=0, busy=0.
  - If hold_full: load the shifter and bit_cnt=WORD_BITS-1, drive spi_mosi=MSB, go to LOW, busy=1.
- State LOW:
  - spi_clk=0; spi_mosi holds the current bit.
  - After CLK_DIV cycles: go to HIGH, spi_clk=1.
- State HIGH:
  - spi_clk=1; spi_mosi is stable.
  - After CLK_DIV cycles, if bit_cnt>0: shift, bit_cnt-1, drive the next bit, go to LOW, spi_clk=0.
  - After CLK_DIV cycles, if bit_cnt==0: pulse word_done for one cycle, then:
    - if hold_full, load the next word directly into LOW with its MSB. No idle gap; the spi_clk period stays uniform.
    - otherwise go to IDLE: spi_clk=0, spi_mosi=0.
- Latency: accept at edge E0 → MSB on spi_mosi and busy=1 after edge E1. First spi_clk rise is CLK_DIV cycles after E1.
- Word time: 2*CLK_DIV*WORD_BITS clk cycles; 32 cycles at the default 16 bits with CLK_DIV=1.
- spi_clk and spi_mosi are registered outputs; no combinational path from the inputs.
- spi_mosi never changes on the same edge that raises spi_clk.
- Simultaneous events:
  - An accept on the same edge as a word finishing with the hold register empty → IDLE for one cycle, then the load.
  - A word already in hold at the finish always streams without a gap.
- Reset mid-word: abort immediately, buffered word discarded, all outputs to reset values. The system must reset the slave at the same time to keep bit alignment.

Optional Feature:
- SPI_TX_CS_EN defined:
  - Adds port spi_cs_n output 1, active-low chip select; reset value 1.
  - Falls on the IDLE→LOW edge, i.e. together with the first MSB.
  - Setup of CLK_DIV cycles before the first spi_clk rise.
  - Stays low across back-to-back words.
  - Rises on the edge entering IDLE.
- Undefined: no spi_cs_n port; behaviour otherwise identical.

Test Plan:
- CLK_DIV=1, reset, then one word 16'hfff0 → 16 spi_clk rises 2 clks apart; MSB-first samples 1111_1111_1111_0000; one word_done; then IDLE with spi_clk=0, spi_mosi=0.
- Back-to-back 16'hfff0 then 16'h0f0f, second offered as soon as in_ready=1 → 32 rises with no gap; word_done pulses exactly 32 clks apart; second word samples as 0x0f0f.
- Backpressure: hold in_valid=1 with three words → in_ready=0 while the hold register is full; each word is accepted exactly once; in_ready rises on the edge the buffered word enters the shifter.
- CLK_DIV=3 with word 16'h8001 → spi_clk high and low phases each 3 clks; spi_mosi is 1 only for the first and last bits; word time 96 clks.
- Reset asserted after 5 bits of 16'ha5c3 → next cycle spi_clk=0, spi_mosi=0, busy=0, in_ready=1; the pending hold word is never transmitted.
- Loopback into spi_slave (shared reset), words 16'ha5c3 and 16'h1234 → slave pixel_clk fires twice with data 0xa5c3 then 0x1234. With SPI_TX_CS_EN, spi_cs_n stays low across both words and returns high on the edge entering IDLE.
